// File: rtl/sram_req_tracker_if.sv
// sram_req_tracker_if: SRAM-like channel between the tracker and one SRAM port.
// The master drives req and payload; the slave answers with addr_ok/data_ok/rdata.
interface sram_req_tracker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    wr;
  logic [1:0]              size;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    addr_ok;
  logic                    data_ok;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_tracker.sv
// sram_req_tracker: in-order SRAM request tracker with flush discard and response FIFO.
// Define SRAM_REQ_TRACKER_ERR_EN to add the sticky proto_err output.
module sram_req_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_DEPTH      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_req,
  input  logic                    in_wr,
  input  logic [1:0]              in_size,
  input  logic [DATA_WIDTH/8-1:0] in_wstrb,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  output logic                    in_addr_ok,
  sram_req_tracker_if.master      sram,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  input  logic                    resp_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] live_cnt,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] discard_cnt,
  output logic                    idle
`ifdef SRAM_REQ_TRACKER_ERR_EN
  ,
  output logic                    proto_err
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [FW-1:0]         fifo_cnt;

  logic          credit;
  logic          accept;
  logic          outstanding;
  logic          live_rsp;
  logic          full;
  logic          push;
  logic          pop;
  logic [CW-1:0] live_nxt;
  logic [CW-1:0] disc_nxt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Live responses must always find room in the FIFO when they return.
  always_comb begin
    credit = (int'(live_cnt) + int'(fifo_cnt) < RESP_DEPTH) &&
             (int'(live_cnt) + int'(discard_cnt) < MAX_OUTSTANDING);
  end

  assign sram.req   = in_req & credit & ~flush & ~reset;
  assign sram.wr    = in_wr;
  assign sram.size  = in_size;
  assign sram.wstrb = in_wstrb;
  assign sram.addr  = in_addr;
  assign sram.wdata = in_wdata;

  assign accept      = sram.req & sram.addr_ok;
  assign in_addr_ok  = accept;
  assign outstanding = (live_cnt != '0) || (discard_cnt != '0);
  assign full        = (fifo_cnt == FW'(RESP_DEPTH));
  assign resp_valid  = (fifo_cnt != '0);
  assign resp_rdata  = mem[rd_ptr];
  assign pop         = resp_valid & resp_ready;
  assign live_rsp    = sram.data_ok & ~flush &
                       (discard_cnt == '0) & (live_cnt != '0);
  assign push        = live_rsp & (~full | pop);
  assign idle        = ~outstanding & ~resp_valid;

  always_comb begin
    live_nxt = live_cnt;
    disc_nxt = discard_cnt;
    if (flush) begin
      live_nxt = '0;
      disc_nxt = discard_cnt + live_cnt
               - CW'(sram.data_ok & outstanding);
    end else begin
      if (sram.data_ok && discard_cnt != '0)
        disc_nxt = discard_cnt - CW'(1);
      live_nxt = live_cnt + CW'(accept) - CW'(live_rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_cnt    <= '0;
      discard_cnt <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
    end else begin
      live_cnt    <= live_nxt;
      discard_cnt <= disc_nxt;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= inc(wr_ptr);
        if (pop)  rd_ptr <= inc(rd_ptr);
        fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sram.rdata;
  end

`ifdef SRAM_REQ_TRACKER_ERR_EN
  logic err_set;
  assign err_set = (sram.data_ok & ~outstanding) | (accept & ~credit);

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (err_set) begin
      proto_err <= 1'b1;
      if (!proto_err)
        $error("sram_req_tracker: protocol violation");
    end
  end
`endif
endmodule

// File: tb/tb_sram_req_tracker.sv
// tb_sram_req_tracker: directed scoreboard bench for sram_req_tracker.
// DUT a uses default depths, DUT b uses RESP_DEPTH=4 for deeper flush cases.
module tb_sram_req_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_req;
  logic        in_wr;
  logic [1:0]  in_size;
  logic [3:0]  in_wstrb;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        resp_ready;
  logic        sel;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  sram_req_tracker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sif_a ();
  sram_req_tracker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sif_b ();

  assign sif_a.addr_ok = addr_ok & ~sel;
  assign sif_a.data_ok = data_ok & ~sel;
  assign sif_a.rdata   = rdata;
  assign sif_b.addr_ok = addr_ok & sel;
  assign sif_b.data_ok = data_ok & sel;
  assign sif_b.rdata   = rdata;

  logic        a_aok, b_aok, a_rv, b_rv, a_idle, b_idle;
  logic [31:0] a_rd, b_rd;
  logic [2:0]  a_live, b_live, a_disc, b_disc;
`ifdef SRAM_REQ_TRACKER_ERR_EN
  logic        a_err, b_err;
`endif

  sram_req_tracker u_a (
    .clk(clk), .reset(reset), .flush(flush & ~sel),
    .in_req(in_req & ~sel), .in_wr(in_wr), .in_size(in_size),
    .in_wstrb(in_wstrb), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_addr_ok(a_aok), .sram(sif_a),
    .resp_valid(a_rv), .resp_rdata(a_rd),
    .resp_ready(resp_ready & ~sel),
    .live_cnt(a_live), .discard_cnt(a_disc), .idle(a_idle)
`ifdef SRAM_REQ_TRACKER_ERR_EN
    , .proto_err(a_err)
`endif
  );

  sram_req_tracker #(.RESP_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .flush(flush & sel),
    .in_req(in_req & sel), .in_wr(in_wr), .in_size(in_size),
    .in_wstrb(in_wstrb), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_addr_ok(b_aok), .sram(sif_b),
    .resp_valid(b_rv), .resp_rdata(b_rd),
    .resp_ready(resp_ready & sel),
    .live_cnt(b_live), .discard_cnt(b_disc), .idle(b_idle)
`ifdef SRAM_REQ_TRACKER_ERR_EN
    , .proto_err(b_err)
`endif
  );

  logic [31:0] m_aok, m_req, m_addr, m_rv, m_rd, m_live, m_disc, m_idle;
  assign m_aok  = 32'(sel ? b_aok : a_aok);
  assign m_req  = 32'(sel ? sif_b.req : sif_a.req);
  assign m_addr = sel ? sif_b.addr : sif_a.addr;
  assign m_rv   = 32'(sel ? b_rv : a_rv);
  assign m_rd   = sel ? b_rd : a_rd;
  assign m_live = 32'(sel ? b_live : a_live);
  assign m_disc = 32'(sel ? b_disc : a_disc);
  assign m_idle = 32'(sel ? b_idle : a_idle);

  // Response monitor: every popped head must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && m_rv[0] && resp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got=%h required=none", m_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_rd !== mon_e) begin
          bad++;
          $display("FAIL resp_data got=%h required=%h", m_rd, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_req  = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    flush   = 1'b0;
    rdata   = '0;
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; quiet();
    in_wr = 1'b0; in_size = 2'd2; in_wstrb = 4'hF;
    in_addr = '0; in_wdata = '0; resp_ready = 1'b1;

    // reset: requests are masked while reset is high
    in_req = 1'b1; addr_ok = 1'b1;
    mid();
    chk("rst_sram_req", m_req, 0);
    chk("rst_addr_ok", m_aok, 0);
    nxt(); nxt();
    reset = 1'b0; quiet();
    mid();
    chk("rst_live", m_live, 0);
    chk("rst_disc", m_disc, 0);
    chk("rst_rv", m_rv, 0);
    chk("rst_idle", m_idle, 1);
    nxt();

    // single read
    in_req = 1'b1; in_addr = 32'h1FC0_0000; addr_ok = 1'b1;
    mid();
    chk("s1_accept", m_aok, 1);
    chk("s1_addr", m_addr, 32'h1FC0_0000);
    nxt();
    quiet();
    mid();
    chk("s1_accept_once", m_aok, 0);
    chk("s1_live", m_live, 1);
    nxt();
    data_ok = 1'b1; rdata = 32'h3C1D_0001;
    exp_q.push_back(32'h3C1D_0001);
    mid(); nxt();
    quiet();
    mid();
    chk("s1_rv", m_rv, 1);
    nxt();
    mid();
    chk("s1_idle", m_idle, 1);
    nxt();

    // write pass-through
    in_req = 1'b1; in_wr = 1'b1; in_addr = 32'h100;
    in_wstrb = 4'h3; in_wdata = 32'hDEAD_BEEF; addr_ok = 1'b1;
    mid();
    chk("wr_pass", 32'(sif_a.wr), 1);
    chk("wstrb_pass", 32'(sif_a.wstrb), 32'h3);
    chk("wdata_pass", sif_a.wdata, 32'hDEAD_BEEF);
    nxt();
    quiet(); in_wr = 1'b0; in_wstrb = 4'hF;
    data_ok = 1'b1; rdata = 32'h0;
    exp_q.push_back(32'h0);
    mid(); nxt();
    quiet();
    mid(); nxt();

    // credit back-pressure, RESP_DEPTH=2
    resp_ready = 1'b0; in_req = 1'b1; addr_ok = 1'b1;
    mid(); chk("s2_acc0", m_aok, 1); nxt();
    mid(); chk("s2_acc1", m_aok, 1); nxt();
    mid();
    chk("s2_req_blocked", m_req, 0);
    chk("s2_live2", m_live, 2);
    nxt();
    data_ok = 1'b1; rdata = 32'h11; exp_q.push_back(32'h11);
    mid(); chk("s2_req_rsp1", m_req, 0); nxt();
    rdata = 32'h22; exp_q.push_back(32'h22);
    mid(); nxt();
    data_ok = 1'b0;
    mid();
    chk("s2_req_fifo_full", m_req, 0);
    chk("s2_live0", m_live, 0);
    nxt();
    resp_ready = 1'b1;
    mid(); chk("s2_req_pop_cycle", m_req, 0); nxt();
    resp_ready = 1'b0;
    mid(); chk("s2_acc_after_pop", m_aok, 1); nxt();
    mid(); chk("s2_req_after_acc", m_req, 0); nxt();
    in_req = 1'b0; addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h33; exp_q.push_back(32'h33);
    resp_ready = 1'b1;
    mid(); nxt();
    data_ok = 1'b0;
    mid(); nxt();
    mid(); chk("s2_idle", m_idle, 1); nxt();

`ifndef SRAM_REQ_TRACKER_ERR_EN
    // stray data_ok at idle is ignored
    data_ok = 1'b1; rdata = 32'hBAD0_0BAD;
    mid(); nxt();
    quiet();
    mid();
    chk("stray_live", m_live, 0);
    chk("stray_disc", m_disc, 0);
    chk("stray_rv", m_rv, 0);
    nxt();
`else
    mid(); chk("proto_err_clear", 32'(a_err), 0); nxt();
`endif

    // reset mid-operation
    in_req = 1'b1; addr_ok = 1'b1;
    mid(); nxt();
    reset = 1'b1;
    mid(); chk("rst2_req", m_req, 0); nxt();
    reset = 1'b0; quiet();
    mid();
    chk("rst2_live", m_live, 0);
    chk("rst2_idle", m_idle, 1);
    nxt();

    // flush with 3 live outstanding, RESP_DEPTH=4
    sel = 1'b1; resp_ready = 1'b1;
    in_req = 1'b1; addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("s3_acc", m_aok, 1); nxt();
    end
    flush = 1'b1;
    mid();
    chk("s3_no_acc_flush", m_aok, 0);
    chk("s3_live3", m_live, 3);
    nxt();
    flush = 1'b0;
    mid();
    chk("s3_live_flushed", m_live, 0);
    chk("s3_disc3", m_disc, 3);
    chk("s3_acc4", m_aok, 1);
    nxt();
    data_ok = 1'b1; rdata = 32'hA;
    mid(); chk("s3_max_cap", m_req, 0); nxt();
    in_req = 1'b0; addr_ok = 1'b0; rdata = 32'hB;
    mid(); chk("s3_disc2", m_disc, 2); nxt();
    rdata = 32'hC;
    mid(); nxt();
    rdata = 32'hD; exp_q.push_back(32'hD);
    mid();
    chk("s3_rv_dropped", m_rv, 0);
    chk("s3_disc0", m_disc, 0);
    chk("s3_live1", m_live, 1);
    nxt();
    data_ok = 1'b0;
    mid(); chk("s3_rv", m_rv, 1); nxt();
    mid(); chk("s3_idle", m_idle, 1); nxt();

    // flush coincident with data_ok, discard=1 live=2
    resp_ready = 1'b0; in_req = 1'b1; addr_ok = 1'b1;
    mid(); nxt();
    quiet(); data_ok = 1'b1; rdata = 32'h55;
    mid(); nxt();
    quiet(); in_req = 1'b1; addr_ok = 1'b1;
    mid(); chk("s4_rv_pre", m_rv, 1); nxt();
    quiet(); flush = 1'b1;
    mid(); nxt();
    quiet(); resp_ready = 1'b1; in_req = 1'b1; addr_ok = 1'b1;
    mid();
    chk("s4_fifo_cleared", m_rv, 0);
    chk("s4_disc1", m_disc, 1);
    nxt();
    mid(); nxt();
    quiet(); flush = 1'b1; data_ok = 1'b1; rdata = 32'hEE;
    mid();
    chk("s4_live2", m_live, 2);
    chk("s4_disc1b", m_disc, 1);
    nxt();
    quiet();
    mid();
    chk("s4_disc2", m_disc, 2);
    chk("s4_live0", m_live, 0);
    chk("s4_rv0", m_rv, 0);
    nxt();
    data_ok = 1'b1; rdata = 32'hF1;
    mid(); nxt();
    rdata = 32'hF2;
    mid(); nxt();
    quiet();
    mid(); chk("s4_idle", m_idle, 1); nxt();

    // simultaneous accept and live data_ok at live_cnt=1
    resp_ready = 1'b0; in_req = 1'b1; addr_ok = 1'b1;
    mid(); nxt();
    data_ok = 1'b1; rdata = 32'h77; exp_q.push_back(32'h77);
    mid(); chk("s5_acc", m_aok, 1); nxt();
    in_req = 1'b0; addr_ok = 1'b0;
    rdata = 32'h88; exp_q.push_back(32'h88);
    resp_ready = 1'b1;
    mid();
    chk("s5_live1", m_live, 1);
    chk("s5_rv", m_rv, 1);
    nxt();
    quiet();
    mid(); nxt();
    mid(); chk("s5_idle", m_idle, 1); nxt();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_req_tracker.md
Name: sram_req_tracker

Overview:
- Parametrised successor to the core's fixed 2-bit inst/data "discard" registers.
- Sits between a pipeline stage (pre-IF or EXE/MEM) and one SRAM-like channel (req/addr_ok/data_ok).
- Tracks up to MAX_OUTSTANDING in-order transactions and, on flush (exception/eret), drops the responses of every request already in flight.
- Buffers surviving responses in a small FIFO with consumer back-pressure, and throttles issue by credit.

Parameters:
- MAX_OUTSTANDING, 4, max accepted-but-unanswered requests, live plus discarded (>=1).
- RESP_DEPTH, 2, response FIFO entries (>=1); also caps live outstanding plus buffered.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, rdata/wdata width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  single-cycle pulse, from ws_ex | ws_eret
- in_req  in  1  stage requests a transaction
- in_wr  in  1  write request
- in_size  in  2  access size
- in_wstrb  in  DATA_WIDTH/8  byte strobes
- in_addr  in  ADDR_WIDTH  address
- in_wdata  in  DATA_WIDTH  write data
- in_addr_ok  out  1  request accepted this cycle
- sram_req  out  1  to SRAM
- sram_wr, sram_size, sram_wstrb, sram_addr, sram_wdata  out  (as in_*)  pass-through of in_*
- sram_addr_ok  in  1  from SRAM
- sram_data_ok  in  1  from SRAM
- sram_rdata  in  DATA_WIDTH  from SRAM
- resp_valid  out  1  FIFO head valid
- resp_rdata  out  DATA_WIDTH  FIFO head data
- resp_ready  in  1  consumer pops head
- live_cnt  out  clog2(MAX_OUTSTANDING+1)  outstanding, non-discarded
- discard_cnt  out  same  outstanding, to be dropped
- idle  out  1  live_cnt==0 && discard_cnt==0 && !resp_valid

Behaviour:
- Reset (sync): live_cnt=0, discard_cnt=0, FIFO empty, resp_valid=0. sram_req=0 and in_addr_ok=0 while reset is high.
- credit = (live_cnt + fifo_cnt < RESP_DEPTH) && (live_cnt + discard_cnt < MAX_OUTSTANDING).
- sram_req = in_req & credit & ~flush & ~reset (combinational).
- accept = sram_req & sram_addr_ok; in_addr_ok = accept.
- Responses arrive in request order; discarded requests are always older than live ones.
- On sram_data_ok, no flush:
  - discard_cnt>0: response dropped, discard_cnt-1.
  - else: rdata pushed to FIFO, live_cnt-1.
  - Credit guarantees the FIFO is never full at a push.
- Counter next state: live_cnt_next = live_cnt + accept - (live response consumed). Simultaneous accept and response are legal and net to zero.
- On flush:
  - live_cnt_next = 0.
  - discard_cnt_next = discard_cnt + live_cnt - sram_data_ok.
  - Any data_ok in the flush cycle is dropped; it is attributed to the oldest outstanding request.
  - FIFO cleared; resp_valid=0 next cycle.
  - No accept can occur in the flush cycle.
- FIFO:
  - First-word fall-through, RESP_DEPTH entries, circular pointers wrapping at RESP_DEPTH.
  - Pop when resp_valid & resp_ready.
  - Push and pop in the same cycle are legal, including when full.
  - Latency: data_ok at cycle N gives resp_valid=1 with that data at N+1.
- Counters never wrap.
- data_ok with live_cnt==discard_cnt==0 is a protocol violation:
  - Response ignored, counters unchanged.
  - Flagged only with the optional feature.
- Reset mid-operation returns to the reset state. Any responses arriving afterwards count as violations; the owner must reset the SRAM side together.

Optional Feature:
- Macro: SRAM_REQ_TRACKER_ERR_EN.
- Defined:
  - Extra output proto_err (1 bit, reset 0).
  - Set sticky on a data_ok with zero outstanding, or on an accept when credit==0.
  - Cleared only by reset.
  - Simulation $error on set.
- Undefined: port absent, violations silently ignored as above.

Test Plan:
- Single read: in_req=1, addr 0x1FC00000, addr_ok same cycle; data_ok 2 cycles later with 0x3C1D0001 -> in_addr_ok=1 one cycle; resp_valid=1, resp_rdata=0x3C1D0001 the cycle after data_ok; idle=1 after pop.
- Credit back-pressure (MAX_OUTSTANDING=4, RESP_DEPTH=2, resp_ready=0, addr_ok=1, in_req=1) -> exactly 2 accepts, then sram_req=0. After 2 data_ok, sram_req stays 0 until one pop, then 1 accept.
- Flush, 3 live outstanding, none returned -> live_cnt=0, discard_cnt=3. Next 3 data_ok (0xA, 0xB, 0xC) dropped, resp_valid stays 0. 4th request's data 0xD delivered.
- Flush coincident with data_ok, discard_cnt=1, live_cnt=2 -> next cycle discard_cnt=2, live_cnt=0, FIFO empty.
- Simultaneous accept and live data_ok at live_cnt=1 -> live_cnt stays 1, FIFO gains 1 entry.
- Stray data_ok at idle (macro defined) -> proto_err=1 next cycle and held; counters stay 0. After reset pulse, proto_err=0 and all outputs at reset values.
